// File: rtl/if_stage_pipelined_pkg.sv
// Shared types and defaults for the pipelined instruction-fetch stage.
// The IF/ID payload is sized to IF_XLEN, so ADDR_W and DATA_W must not exceed it.
package if_pkg;

  localparam int          IF_XLEN       = 32;
  localparam int          PC_STEP_DEF   = 4;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ      = 2'd0,
    NPC_HOLD     = 2'd1,
    NPC_REDIRECT = 2'd2
  } npc_sel_e;

  typedef struct packed {
    logic [IF_XLEN-1:0] instr;
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] pc_plus4;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_pipelined_if.sv
// Instruction-memory port: the fetch stage is master (address/request out, data/ready in).
interface if_stage_pipelined_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_req_o;
  logic [DATA_W-1:0] imem_rdata_i;
  logic              imem_ready_i;

  modport master (output imem_addr_o, imem_req_o, input imem_rdata_i, imem_ready_i);
  modport slave  (input imem_addr_o, imem_req_o, output imem_rdata_i, imem_ready_i);
endinterface

// File: rtl/if_stage_pipelined_next_pc.sv
// Combinational next-PC selection: redirect > hold (stall or fetch wait) > sequential.
// With IF_ALIGN_CHECK_EN defined, redirect targets are forced to word alignment.
module if_next_pc
  import if_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [ADDR_W-1:0] pc_plus_step_o,
  output npc_sel_e          sel_o
);

  logic [ADDR_W-1:0] w_target;

  assign pc_plus_step_o = pc_i + ADDR_W'(PC_STEP);

`ifdef IF_ALIGN_CHECK_EN
  assign w_target = {branch_target_i[ADDR_W-1:2], 2'b00};
`else
  assign w_target = branch_target_i;
`endif

  always_comb begin
    sel_o     = NPC_SEQ;
    next_pc_o = pc_plus_step_o;
    if (branch_taken_i) begin
      sel_o     = NPC_REDIRECT;
      next_pc_o = w_target;
    end else if (stall_i || !imem_ready_i) begin
      sel_o     = NPC_HOLD;
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/if_stage_pipelined.sv
// Instruction-fetch stage: PC register, imem request and the IF/ID pipeline register.
// Optional IF_ALIGN_CHECK_EN adds if_misalign_o, a one-cycle pulse on a misaligned redirect.
module if_stage_pipelined
  import if_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PC_STEP   = PC_STEP_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                branch_taken_i,
  input  logic [ADDR_W-1:0]   branch_target_i,
  if_stage_pipelined_if.master imem,
  output logic [ADDR_W-1:0]   pc_o,
  output logic [DATA_W-1:0]   if_id_instr_o,
  output logic [ADDR_W-1:0]   if_id_pc_o,
  output logic [ADDR_W-1:0]   if_id_pc_plus4_o,
  output logic                if_id_valid_o
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic                if_misalign_o
`endif
);

  logic [ADDR_W-1:0] r_pc;
  if_id_t            r_if_id;
  if_id_t            w_if_id_nxt;
  if_id_t            w_bubble;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_pc_plus_step;
  npc_sel_e          w_sel;

  if_next_pc #(
    .ADDR_W (ADDR_W),
    .PC_STEP(PC_STEP)
  ) u_next_pc (
    .pc_i           (r_pc),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .imem_ready_i   (imem.imem_ready_i),
    .next_pc_o      (w_next_pc),
    .pc_plus_step_o (w_pc_plus_step),
    .sel_o          (w_sel)
  );

  // A bubble keeps the previous PC fields so downstream probes stay stable.
  always_comb begin
    w_bubble       = r_if_id;
    w_bubble.instr = IF_XLEN'(DATA_W'(NOP_INSTR));
    w_bubble.valid = 1'b0;
  end

  always_comb begin
    w_if_id_nxt = r_if_id;
    case (w_sel)
      NPC_REDIRECT: w_if_id_nxt = w_bubble;
      NPC_HOLD: begin
        if (!stall_i || flush_i) w_if_id_nxt = w_bubble;
      end
      default: begin
        w_if_id_nxt.instr    = flush_i ? IF_XLEN'(DATA_W'(NOP_INSTR))
                                       : IF_XLEN'(imem.imem_rdata_i);
        w_if_id_nxt.pc       = IF_XLEN'(r_pc);
        w_if_id_nxt.pc_plus4 = IF_XLEN'(w_pc_plus_step);
        w_if_id_nxt.valid    = ~flush_i;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc             <= ADDR_W'(RESET_PC);
      r_if_id.instr    <= IF_XLEN'(DATA_W'(NOP_INSTR));
      r_if_id.pc       <= '0;
      r_if_id.pc_plus4 <= '0;
      r_if_id.valid    <= 1'b0;
    end else begin
      r_pc    <= w_next_pc;
      r_if_id <= w_if_id_nxt;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= branch_taken_i && (branch_target_i[1:0] != 2'b00);
  end

  assign if_misalign_o = r_misalign;
`endif

  assign imem.imem_addr_o = r_pc;
  assign imem.imem_req_o  = rst_n & ~branch_taken_i;
  assign pc_o             = r_pc;
  assign if_id_instr_o    = DATA_W'(r_if_id.instr);
  assign if_id_pc_o       = ADDR_W'(r_if_id.pc);
  assign if_id_pc_plus4_o = ADDR_W'(r_if_id.pc_plus4);
  assign if_id_valid_o    = r_if_id.valid;

endmodule

// File: tb/tb_if_stage_pipelined.sv
// Self-checking bench for if_stage_pipelined: directed vector table plus an async-reset sequence.
// Memory model returns 32'h1000_0000 + word index for every address.
module tb_if_stage_pipelined;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;
  logic        if_id_valid_o;
`ifdef IF_ALIGN_CHECK_EN
  logic        if_misalign_o;
`endif

  int n_err = 0;
  int n_chk = 0;

  if_stage_pipelined_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();

  if_stage_pipelined #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .PC_STEP(4), .NOP_INSTR(32'h0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem            (imem_bus),
    .pc_o            (pc_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_pc_o      (if_id_pc_o),
    .if_id_pc_plus4_o(if_id_pc_plus4_o),
    .if_id_valid_o   (if_id_valid_o)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .if_misalign_o   (if_misalign_o)
`endif
  );

  always_comb imem_bus.imem_rdata_i = 32'h1000_0000 + {2'b00, imem_bus.imem_addr_o[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, br, rdy;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_instr, e_ifpc, e_plus4;
    logic        e_valid, c_instr, c_pcs, e_mis;
  } vec_t;

  vec_t v[21];

  function automatic vec_t mk(logic s, logic f, logic b, logic r, logic [31:0] t,
                              logic [31:0] pc, logic [31:0] ins, logic [31:0] ipc,
                              logic [31:0] p4, logic val, logic ci, logic cp, logic mis);
    vec_t x;
    x.stall = s; x.flush = f; x.br = b; x.rdy = r; x.tgt = t;
    x.e_pc = pc; x.e_instr = ins; x.e_ifpc = ipc; x.e_plus4 = p4;
    x.e_valid = val; x.c_instr = ci; x.c_pcs = cp; x.e_mis = mis;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] cur_pc;

  initial begin
    //      st fl br rdy tgt           pc            instr         ifpc          plus4        val ci cp mis
    v[0]  = mk(0, 0, 0, 1, 32'h0,        32'h4,        32'h1000_0000, 32'h0,        32'h4,        1, 1, 1, 0);
    v[1]  = mk(0, 0, 0, 1, 32'h0,        32'h8,        32'h1000_0001, 32'h4,        32'h8,        1, 1, 1, 0);
    v[2]  = mk(0, 0, 1, 1, 32'h10,       32'h10,       32'h0,         32'h4,        32'h8,        0, 1, 1, 0);
    v[3]  = mk(0, 0, 0, 1, 32'h0,        32'h14,       32'h1000_0004, 32'h10,       32'h14,       1, 1, 1, 0);
    v[4]  = mk(0, 0, 0, 1, 32'h0,        32'h18,       32'h1000_0005, 32'h14,       32'h18,       1, 1, 1, 0);
    v[5]  = mk(1, 0, 0, 1, 32'h0,        32'h18,       32'h1000_0005, 32'h14,       32'h18,       1, 1, 1, 0);
    v[6]  = mk(1, 0, 0, 0, 32'h0,        32'h18,       32'h1000_0005, 32'h14,       32'h18,       1, 1, 1, 0);
    v[7]  = mk(1, 1, 0, 1, 32'h0,        32'h18,       32'h0,         32'h14,       32'h18,       0, 1, 1, 0);
    v[8]  = mk(0, 0, 0, 1, 32'h0,        32'h1C,       32'h1000_0006, 32'h18,       32'h1C,       1, 1, 1, 0);
    v[9]  = mk(0, 0, 0, 0, 32'h0,        32'h1C,       32'h0,         32'h18,       32'h1C,       0, 1, 1, 0);
    v[10] = mk(0, 0, 0, 0, 32'h0,        32'h1C,       32'h0,         32'h18,       32'h1C,       0, 1, 1, 0);
    v[11] = mk(0, 0, 0, 0, 32'h0,        32'h1C,       32'h0,         32'h18,       32'h1C,       0, 1, 1, 0);
    v[12] = mk(0, 0, 0, 1, 32'h0,        32'h20,       32'h1000_0007, 32'h1C,       32'h20,       1, 1, 1, 0);
    v[13] = mk(0, 1, 0, 1, 32'h0,        32'h24,       32'h0,         32'h0,        32'h0,        0, 0, 0, 0);
    v[14] = mk(1, 0, 1, 1, 32'h20,       32'h20,       32'h0,         32'h0,        32'h0,        0, 1, 0, 0);
    v[15] = mk(0, 0, 1, 0, 32'h40,       32'h40,       32'h0,         32'h0,        32'h0,        0, 1, 0, 0);
    v[16] = mk(0, 0, 0, 1, 32'h0,        32'h44,       32'h1000_0010, 32'h40,       32'h44,       1, 1, 1, 0);
    v[17] = mk(0, 0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       32'h40,       32'h44,       0, 1, 1, 0);
    v[18] = mk(0, 0, 0, 1, 32'h0,        32'h0,        32'h4FFF_FFFF, 32'hFFFF_FFFC, 32'h0,       1, 1, 1, 0);
`ifdef IF_ALIGN_CHECK_EN
    v[19] = mk(0, 0, 1, 1, 32'h22,       32'h20,       32'h0,         32'hFFFF_FFFC, 32'h0,       0, 1, 1, 1);
    v[20] = mk(0, 0, 0, 1, 32'h0,        32'h24,       32'h1000_0008, 32'h20,       32'h24,       1, 1, 1, 0);
`else
    v[19] = mk(0, 0, 1, 1, 32'h22,       32'h22,       32'h0,         32'hFFFF_FFFC, 32'h0,       0, 1, 1, 1);
    v[20] = mk(0, 0, 0, 1, 32'h0,        32'h26,       32'h1000_0008, 32'h22,       32'h26,       1, 1, 1, 0);
`endif

    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; branch_taken_i = 1'b0;
    branch_target_i = 32'h0; imem_bus.imem_ready_i = 1'b1;

    #1;
    chk("rst_pc",    pc_o,                  32'h0);
    chk("rst_instr", if_id_instr_o,         32'h0);
    chk("rst_ifpc",  if_id_pc_o,            32'h0);
    chk("rst_plus4", if_id_pc_plus4_o,      32'h0);
    chk("rst_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("rst_req",   {31'b0, imem_bus.imem_req_o}, 32'h0);
`ifdef IF_ALIGN_CHECK_EN
    chk("rst_mis",   {31'b0, if_misalign_o}, 32'h0);
`endif

    @(negedge clk);
    rst_n  = 1'b1;
    cur_pc = 32'h0;

    for (int i = 0; i < 21; i++) begin
      stall_i = v[i].stall; flush_i = v[i].flush; branch_taken_i = v[i].br;
      branch_target_i = v[i].tgt; imem_bus.imem_ready_i = v[i].rdy;
      #1;
      chk($sformatf("v%0d_req", i),  {31'b0, imem_bus.imem_req_o}, {31'b0, ~v[i].br});
      chk($sformatf("v%0d_addr", i), imem_bus.imem_addr_o, cur_pc);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i),    pc_o, v[i].e_pc);
      chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid_o}, {31'b0, v[i].e_valid});
      if (v[i].c_instr) chk($sformatf("v%0d_instr", i), if_id_instr_o, v[i].e_instr);
      if (v[i].c_pcs) begin
        chk($sformatf("v%0d_ifpc", i),  if_id_pc_o,       v[i].e_ifpc);
        chk($sformatf("v%0d_plus4", i), if_id_pc_plus4_o, v[i].e_plus4);
      end
`ifdef IF_ALIGN_CHECK_EN
      chk($sformatf("v%0d_mis", i), {31'b0, if_misalign_o}, {31'b0, v[i].e_mis});
`endif
      cur_pc = v[i].e_pc;
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a clock phase.
    stall_i = 1'b0; flush_i = 1'b0; branch_taken_i = 1'b0; imem_bus.imem_ready_i = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc",    pc_o,                   32'h0);
    chk("arst_instr", if_id_instr_o,          32'h0);
    chk("arst_ifpc",  if_id_pc_o,             32'h0);
    chk("arst_plus4", if_id_pc_plus4_o,       32'h0);
    chk("arst_valid", {31'b0, if_id_valid_o}, 32'h0);
    chk("arst_req",   {31'b0, imem_bus.imem_req_o}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_pc",    pc_o,                   32'h4);
    chk("post_instr", if_id_instr_o,          32'h1000_0000);
    chk("post_ifpc",  if_id_pc_o,             32'h0);
    chk("post_plus4", if_id_pc_plus4_o,       32'h4);
    chk("post_valid", {31'b0, if_id_valid_o}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
